uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised, buffered UART transmitter; successor to the fixed 8E1 transmitter.
//  Accepts words over a valid/ready stream into an internal FIFO and serialises them LSB-first.
//  Frame format is programmable at run time: parity none/even/odd, 1 or 2 stop bits, baud divisor.
//  Sits between the on-chip stream producer (debug/console path) and the TX pad.
// PARAMETERS
//  DATA_BITS  8      data bits per frame, legal 5..9; width of s_data
//  FIFO_DEPTH 4      FIFO entries, power of two, >=2
//  DIV_W      16     width of cfg_div
// PORTS
//  clk         in   1          single clock; all logic on rising edge
//  rst         in   1          synchronous reset, active-high
//  s_valid     in   1          producer has a word
//  s_ready     out  1          FIFO can accept; equals !full
//  s_data      in   DATA_BITS  word to send, bit 0 first on the line
//  cfg_div     in   DIV_W      clocks per bit; value 0 treated as 1
//  cfg_parity  in   2          00 none, 01 even, 10 odd, 11 reserved (= none)
//  cfg_stop2   in   1          1 = two stop bits, 0 = one
//  tx_out      out  1          serial line, idle high, registered
//  tx_busy     out  1          high while a frame is on the line (START..STOP)
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  frame_done  out  1          one-cycle pulse in the last clock of the stop period
// BEHAVIOUR
//  Reset (synchronous, rst=1 at a rising edge): tx_out=1, tx_busy=0, frame_done=0, s_ready=1,
//   fifo_level=0, state IDLE, FIFO flushed. Reset mid-frame aborts it; tx_out is 1 on the next cycle.
//  Push: a word is written on any edge with s_valid && s_ready. s_ready is !full only, so a full
//   FIFO refuses a push even when a pop happens in the same cycle. Push and pop in one cycle: level unchanged.
//  Config (cfg_div, cfg_parity, cfg_stop2) is latched when a word is popped. Changes mid-frame
//   do not affect that frame.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//   IDLE : tx_out=1, tx_busy=0. If FIFO is non-empty at an edge: pop, load shift register and
//          parity, tx_out<=0, go to START. Latency is 1 cycle from the accepting edge to tx_out low
//          when the FIFO was empty.
//   START: the line is low for exactly D clocks (D = latched divisor, min 1).
//   DATA : DATA_BITS bits, LSB first, D clocks each.
//   PARITY: skipped when mode is none. Even = ^data. Odd = ~^data. Lasts D clocks.
//   STOP : high for D clocks, or 2*D when stop2=1. frame_done=1 in its final clock. At the end of
//          STOP, if the FIFO is non-empty, pop and go straight to START with no idle cycle;
//          otherwise go to IDLE.
//  Frame length = D*(1+DATA_BITS+P+S) clocks, where P is 0 or 1 and S is 1 or 2.
//  Bit counter wraps at DATA_BITS-1. Divisor counter counts 0..D-1.
//  tx_busy is 1 from the first START clock through the last STOP clock.
//  Reserved parity code 11 behaves exactly as none.
//  No errors and no overflow are possible: the producer stalls on s_ready=0.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> tx_out=1, s_ready=1, fifo_level=0, tx_busy=0.
//  2 DATA_BITS=8, div=4, parity=01, stop2=0, send 0xA5 ->
//    line 0,1,0,1,0,0,1,0,1,0,1, each bit 4 clocks; 44 clocks total; parity=0; one frame_done pulse.
//  3 Same setup with parity=10 and stop2=1, send 0x01 ->
//    parity bit 0, stop high 8 clocks, frame 48 clocks.
//  4 FIFO_DEPTH=4, div=2, parity=00, push 6 words with s_valid held high ->
//    s_ready drops once 4 are queued (1 in flight + 4 queued after first pop);
//    all 6 sent back-to-back with no idle cycle between frames.
//  5 cfg_div=0 -> each bit is 1 clock. Change cfg_div from 4 to 8 mid-frame ->
//    current frame stays 4, next frame uses 8.
//  6 Assert rst during DATA of frame 1 with 2 words queued ->
//    tx_out=1 next cycle, fifo_level=0, no further frames.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
//   Buffered UART transmitter with a run-time programmable frame format.
//   Words enter over a valid/ready stream into a small FIFO and are sent
//   LSB first: START, DATA_BITS data bits, optional parity, 1 or 2 STOP bits.
//   The frame format (divisor, parity mode, stop bits) is captured when a
//   word leaves the FIFO, so mid-frame configuration changes only affect
//   later frames.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous reset, active high
//   s_valid     producer has a word
//   s_ready     FIFO not full
//   s_data      word to send, bit 0 first on the line
//   cfg_div     clocks per bit (0 behaves as 1)
//   cfg_parity  00 none, 01 even, 10 odd, 11 none
//   cfg_stop2   1 = two stop bits
//   tx_out      serial line, idle high, registered
//   tx_busy     high from the first START clock to the last STOP clock
//   fifo_level  FIFO occupancy
//   frame_done  one-cycle pulse in the last clock of the STOP period
//
// state  | meaning
// IDLE   | line high, waiting for a word in the FIFO
// START  | start bit (low), D clocks
// DATA   | data bits LSB first, D clocks each
// PARITY | parity bit, D clocks (skipped when parity is off)
// STOP   | stop bit(s) high, D or 2*D clocks

module uart_tx_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_BITS-1:0]          s_data,
   input  logic [DIV_W-1:0]              cfg_div,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   output logic                          tx_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t state, state_nx;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic                 push, pop, empty, full;
   logic [DATA_BITS-1:0] rd_data;

   logic [DIV_W-1:0]     div_cnt, d_lat;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, par_en_lat, stop2_lat, stop_cnt;
   logic                 bit_end, bit_last, stop_end, tx_d;

   // FIFO
   assign empty   = (fifo_level == '0);
   assign full    = (fifo_level == LW'(FIFO_DEPTH));
   assign s_ready = !full;
   assign push    = s_valid && s_ready;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
      end
   end

   // bit timing
   assign bit_end  = (div_cnt == d_lat - DIV_W'(1));
   assign bit_last = (bit_cnt == BW'(DATA_BITS - 1));
   // second stop bit is tracked by stop_cnt so the divisor counter never needs 2*D
   assign stop_end = (state == STOP) && bit_end && (!stop2_lat || stop_cnt);

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // FSM: next state
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               state_nx = START;
            end
         end
         START: begin
            if (bit_end)
               state_nx = DATA;
         end
         DATA: begin
            if (bit_end && bit_last)
               state_nx = par_en_lat ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end)
               state_nx = STOP;
         end
         STOP: begin
            if (stop_end) begin
               if (!empty) begin
                  pop      = 1'b1;
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM: outputs; tx_d is the line value for the coming cycle
   always_comb begin
      tx_busy    = (state != IDLE);
      frame_done = stop_end;
      tx_d       = 1'b1;
      case (state_nx)
         START:   tx_d = 1'b0;
         // shreg shifts on the same edge, so look one bit ahead when moving on
         DATA:    tx_d = (state == DATA && bit_end) ? shreg[1] : shreg[0];
         PARITY:  tx_d = par_bit;
         default: tx_d = 1'b1;
      endcase
   end

   // datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_out     <= 1'b1;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         par_en_lat <= 1'b0;
         stop2_lat  <= 1'b0;
         d_lat      <= DIV_W'(1);
      end else begin
         tx_out <= tx_d;
         if (pop) begin
            shreg      <= rd_data;
            par_bit    <= cfg_parity[1] ? ~^rd_data : ^rd_data;
            par_en_lat <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            stop2_lat  <= cfg_stop2;
            d_lat      <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
         end else if (state != IDLE) begin
            if (bit_end) begin
               div_cnt <= '0;
               if (state == DATA && !bit_last) begin
                  bit_cnt <= bit_cnt + BW'(1);
                  shreg   <= shreg >> 1;
               end
               if (state == STOP)
                  stop_cnt <= 1'b1;
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic [15:0] cfg_div;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        tx_out;
   logic        tx_busy;
   logic [2:0]  fifo_level;
   logic        frame_done;

   uart_tx_cfg #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .cfg_div    (cfg_div),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .tx_out     (tx_out),
      .tx_busy    (tx_busy),
      .fifo_level (fifo_level),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // pat: line value per bit slot, slot 0 (start) in bit 0
   typedef struct {
      logic [11:0] pat;
      int          nbits;
      int          div;
      bit          b2b;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   bit   mon_busy = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [11:0] pat, input int nbits, input int div, input bit b2b);
      exp_t e;
      e.pat   = pat;
      e.nbits = nbits;
      e.div   = div;
      e.b2b   = b2b;
      return e;
   endfunction

   // offer one word; returns just after the accepting edge with s_valid still high
   task automatic send(input logic [7:0] d, input exp_t e, input bit use_exp);
      int t = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", t);
      end
      if (use_exp)
         exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int t = 0;
      while ((exp_q.size() != 0 || mon_busy) && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending_frames", exp_q.size() + int'(mon_busy), 0);
      repeat (5) @(negedge clk);
   endtask

   // monitor: decodes the line and compares each frame with the queue head
   initial begin : monitor
      int   gap;
      int   total, lerr, berr, derr;
      exp_t e;
      gap = 1000;
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            gap = 1000;
         end else if (tx_out === 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: line low with no frame expected");
               gap = 0;
            end else begin
               e = exp_q.pop_front();
               mon_busy = 1'b1;
               if (e.b2b)
                  chk("back_to_back_gap", gap, 0);
               total = e.nbits * e.div;
               lerr = 0;
               berr = 0;
               derr = 0;
               for (int c = 0; c < total; c++) begin
                  if (c > 0)
                     @(negedge clk);
                  if (tx_out !== e.pat[c / e.div])
                     lerr++;
                  if (tx_busy !== 1'b1)
                     berr++;
                  if (frame_done !== (c == total - 1))
                     derr++;
               end
               chk("frame_line_bad_cycles", lerr, 0);
               chk("frame_busy_bad_cycles", berr, 0);
               chk("frame_done_bad_cycles", derr, 0);
               mon_busy = 1'b0;
               gap = 0;
            end
         end else begin
            chk("idle_frame_done", int'(frame_done), 0);
            chk("idle_tx_busy", int'(tx_busy), 0);
            gap++;
         end
      end
   end

   initial begin : stimulus
      logic [7:0] w [6];
      w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
      w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;

      rst        = 1'b1;
      s_valid    = 1'b0;
      s_data     = 8'h00;
      cfg_div    = 16'd4;
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;

      // reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_tx_out", int'(tx_out), 1);
      chk("reset_s_ready", int'(s_ready), 1);
      chk("reset_fifo_level", int'(fifo_level), 0);
      chk("reset_tx_busy", int'(tx_busy), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);

      // 8E1, div 4, 0xA5: 0,1,0,1,0,0,1,0,1,0,1
      cfg_div    = 16'd4;
      cfg_parity = 2'b01;
      cfg_stop2  = 1'b0;
      send(8'hA5, mk({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 1'b0), 1'b1);
      s_valid = 1'b0;
      @(negedge clk);
      chk("latency_line_still_idle", int'(tx_out), 1);
      chk("latency_level_after_push", int'(fifo_level), 1);
      @(negedge clk);
      chk("latency_line_low", int'(tx_out), 0);
      chk("latency_level_after_pop", int'(fifo_level), 0);
      wait_drain(200);

      // 8O2, div 4, 0x01: parity 0, 8 stop clocks, 48 clocks
      cfg_parity = 2'b10;
      cfg_stop2  = 1'b1;
      send(8'h01, mk({2'b11, 1'b0, 8'h01, 1'b0}, 12, 4, 1'b0), 1'b1);
      s_valid = 1'b0;
      wait_drain(200);

      // six words, s_valid held, div 2, no parity, back to back
      cfg_div    = 16'd2;
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(w[i], mk({1'b1, w[i], 1'b0}, 10, 2, i > 0), 1'b1);
         if (i == 4) begin
            chk("full_s_ready", int'(s_ready), 0);
            chk("full_fifo_level", int'(fifo_level), 4);
         end
      end
      s_valid = 1'b0;
      wait_drain(600);

      // reserved parity code behaves as none; divisor 0 behaves as 1
      cfg_div    = 16'd0;
      cfg_parity = 2'b11;
      send(8'h3C, mk({1'b1, 8'h3C, 1'b0}, 10, 1, 1'b0), 1'b1);
      s_valid = 1'b0;
      wait_drain(100);

      // divisor change mid-frame applies to the next frame only
      cfg_div    = 16'd4;
      cfg_parity = 2'b00;
      send(8'h5A, mk({1'b1, 8'h5A, 1'b0}, 10, 4, 1'b0), 1'b1);
      s_valid = 1'b0;
      repeat (6) @(negedge clk);
      cfg_div = 16'd8;
      send(8'hC3, mk({1'b1, 8'hC3, 1'b0}, 10, 8, 1'b1), 1'b1);
      s_valid = 1'b0;
      wait_drain(400);

      // reset during DATA of frame 1 with two words queued
      mon_en  = 1'b0;
      cfg_div = 16'd4;
      send(8'hF0, mk(12'h000, 0, 1, 1'b0), 1'b0);
      send(8'h0F, mk(12'h000, 0, 1, 1'b0), 1'b0);
      send(8'hAA, mk(12'h000, 0, 1, 1'b0), 1'b0);
      s_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("abort_busy_before", int'(tx_busy), 1);
      chk("abort_level_before", int'(fifo_level), 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_tx_out", int'(tx_out), 1);
      chk("abort_fifo_level", int'(fifo_level), 0);
      chk("abort_tx_busy", int'(tx_busy), 0);
      chk("abort_s_ready", int'(s_ready), 1);
      begin
         int act = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b0 || fifo_level !== 3'd0)
               act++;
         end
         chk("abort_no_more_frames", act, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
